// File: rtl/scoreboard_wakeup.sv
// Register-readiness scoreboard with per-tag latency countdown after issue broadcast.
// Optional macro SCOREBOARD_RECOVERY_EN adds flush_valid/flush_mask recovery ports.
module scoreboard_wakeup #(
    parameter int unsigned DW          = 2,
    parameter int unsigned BW          = 2,
    parameter int unsigned PHY_REG_NUM = 64,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned LAT_ALU     = 1,
    parameter int unsigned LAT_BR      = 1,
    parameter int unsigned LAT_MUL     = 3,
    parameter int unsigned LAT_LDST    = 4,
    parameter int unsigned RS_ENT_SEL  = 3,
    localparam int unsigned PHY_REG_SEL = $clog2(PHY_REG_NUM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DW-1:0]               disp_valid,
    input  logic [DW*PHY_REG_SEL-1:0]   disp_src1,
    input  logic [DW*PHY_REG_SEL-1:0]   disp_src2,
    input  logic [DW*PHY_REG_SEL-1:0]   disp_dst,
    input  logic [DW-1:0]               disp_wr_reg,
    input  logic [DW*RS_ENT_SEL-1:0]    disp_type,
    output logic [DW-1:0]               src1_ready,
    output logic [DW-1:0]               src1_match,
    output logic [DW*LAT_W-1:0]         src1_cnt,
    output logic [DW-1:0]               src2_ready,
    output logic [DW-1:0]               src2_match,
    output logic [DW*LAT_W-1:0]         src2_cnt,
    input  logic [BW-1:0]               bc_valid,
    input  logic [BW*PHY_REG_SEL-1:0]   bc_dst,
`ifdef SCOREBOARD_RECOVERY_EN
    input  logic                        flush_valid,
    input  logic [PHY_REG_NUM-1:0]      flush_mask,
`endif
    output logic [PHY_REG_SEL:0]        busy_cnt
);

    localparam int unsigned CW = PHY_REG_SEL + 1;

    localparam logic [RS_ENT_SEL-1:0] RS_ENT_ALU    = RS_ENT_SEL'(1);
    localparam logic [RS_ENT_SEL-1:0] RS_ENT_BRANCH = RS_ENT_SEL'(2);
    localparam logic [RS_ENT_SEL-1:0] RS_ENT_MUL    = RS_ENT_SEL'(3);
    localparam logic [RS_ENT_SEL-1:0] RS_ENT_LDST   = RS_ENT_SEL'(4);

    logic [PHY_REG_NUM-1:0] ready_q, ready_d;
    logic [PHY_REG_NUM-1:0] match_q, match_d;
    logic [LAT_W-1:0]       lat_q [PHY_REG_NUM];
    logic [LAT_W-1:0]       lat_d [PHY_REG_NUM];
    logic [LAT_W-1:0]       cnt_q [PHY_REG_NUM];
    logic [LAT_W-1:0]       cnt_d [PHY_REG_NUM];
    logic [CW-1:0]          busy_q, busy_d;

    function automatic logic [LAT_W-1:0] type_lat(input logic [RS_ENT_SEL-1:0] t);
        case (t)
            RS_ENT_ALU:    return LAT_W'(LAT_ALU);
            RS_ENT_BRANCH: return LAT_W'(LAT_BR);
            RS_ENT_MUL:    return LAT_W'(LAT_MUL);
            RS_ENT_LDST:   return LAT_W'(LAT_LDST);
            default:       return LAT_W'(1);
        endcase
    endfunction

    // Source lookups read pre-edge state; idle slots report all-zero.
    always_comb begin
        src1_ready = '0;
        src1_match = '0;
        src1_cnt   = '0;
        src2_ready = '0;
        src2_match = '0;
        src2_cnt   = '0;
        for (int k = 0; k < DW; k++) begin
            if (disp_valid[k]) begin
                src1_ready[k] = ready_q[disp_src1[k*PHY_REG_SEL +: PHY_REG_SEL]];
                src1_match[k] = match_q[disp_src1[k*PHY_REG_SEL +: PHY_REG_SEL]];
                src1_cnt[k*LAT_W +: LAT_W] = cnt_q[disp_src1[k*PHY_REG_SEL +: PHY_REG_SEL]];
                src2_ready[k] = ready_q[disp_src2[k*PHY_REG_SEL +: PHY_REG_SEL]];
                src2_match[k] = match_q[disp_src2[k*PHY_REG_SEL +: PHY_REG_SEL]];
                src2_cnt[k*LAT_W +: LAT_W] = cnt_q[disp_src2[k*PHY_REG_SEL +: PHY_REG_SEL]];
            end
        end
    end

    // Lowest priority applied first so later stages override: countdown, broadcast, dispatch, flush.
    always_comb begin
        ready_d = ready_q;
        match_d = match_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        busy_d  = '0;
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            if (match_q[i] && !ready_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i]   = cnt_q[i] - LAT_W'(1);
                ready_d[i] = (cnt_q[i] == LAT_W'(1));
            end
        end
        for (int j = 0; j < BW; j++) begin
            if (bc_valid[j]) begin
                match_d[bc_dst[j*PHY_REG_SEL +: PHY_REG_SEL]] = 1'b1;
                cnt_d[bc_dst[j*PHY_REG_SEL +: PHY_REG_SEL]] =
                    lat_q[bc_dst[j*PHY_REG_SEL +: PHY_REG_SEL]] - LAT_W'(1);
                ready_d[bc_dst[j*PHY_REG_SEL +: PHY_REG_SEL]] =
                    ready_q[bc_dst[j*PHY_REG_SEL +: PHY_REG_SEL]] ||
                    (lat_q[bc_dst[j*PHY_REG_SEL +: PHY_REG_SEL]] == LAT_W'(1));
            end
        end
        for (int k = 0; k < DW; k++) begin
            if (disp_valid[k] && disp_wr_reg[k]) begin
                ready_d[disp_dst[k*PHY_REG_SEL +: PHY_REG_SEL]] = 1'b0;
                match_d[disp_dst[k*PHY_REG_SEL +: PHY_REG_SEL]] = 1'b0;
                cnt_d[disp_dst[k*PHY_REG_SEL +: PHY_REG_SEL]]   = '0;
                lat_d[disp_dst[k*PHY_REG_SEL +: PHY_REG_SEL]]   =
                    type_lat(disp_type[k*RS_ENT_SEL +: RS_ENT_SEL]);
            end
        end
`ifdef SCOREBOARD_RECOVERY_EN
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            if (flush_valid && flush_mask[i]) begin
                ready_d[i] = 1'b1;
                match_d[i] = 1'b1;
                cnt_d[i]   = '0;
            end
        end
`endif
        // p0 is hardwired ready.
        ready_d[0] = 1'b1;
        match_d[0] = 1'b1;
        cnt_d[0]   = '0;
        lat_d[0]   = LAT_W'(1);
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            busy_d = busy_d + CW'(!ready_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= '1;
            match_q <= '1;
            busy_q  <= '0;
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                lat_q[i] <= LAT_W'(1);
                cnt_q[i] <= '0;
            end
        end else begin
            ready_q <= ready_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                lat_q[i] <= lat_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign busy_cnt = busy_q;

endmodule

// File: tb/tb_scoreboard_wakeup.sv
// Randomized bench for scoreboard_wakeup against a timestamp-based readiness model.
module tb_scoreboard_wakeup;
    localparam int unsigned DW  = 2;
    localparam int unsigned BW  = 2;
    localparam int unsigned NR  = 64;
    localparam int unsigned SEL = 6;
    localparam int unsigned LW  = 3;
    localparam int unsigned TW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [DW-1:0]     disp_valid, disp_wr_reg;
    logic [DW*SEL-1:0] disp_src1, disp_src2, disp_dst;
    logic [DW*TW-1:0]  disp_type;
    logic [DW-1:0]     src1_ready, src1_match, src2_ready, src2_match;
    logic [DW*LW-1:0]  src1_cnt, src2_cnt;
    logic [BW-1:0]     bc_valid;
    logic [BW*SEL-1:0] bc_dst;
    logic [SEL:0]      busy_cnt;
`ifdef SCOREBOARD_RECOVERY_EN
    logic              flush_valid;
    logic [NR-1:0]     flush_mask;
`endif

    scoreboard_wakeup dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_dst(disp_dst), .disp_wr_reg(disp_wr_reg), .disp_type(disp_type),
        .src1_ready(src1_ready), .src1_match(src1_match), .src1_cnt(src1_cnt),
        .src2_ready(src2_ready), .src2_match(src2_match), .src2_cnt(src2_cnt),
        .bc_valid(bc_valid), .bc_dst(bc_dst),
`ifdef SCOREBOARD_RECOVERY_EN
        .flush_valid(flush_valid), .flush_mask(flush_mask),
`endif
        .busy_cnt(busy_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A register is pending from its dispatch until lat-1 edges after its broadcast edge.
    bit m_pend [NR];
    bit m_bcd  [NR];
    int m_lat  [NR];
    int m_bce  [NR];
    int m_e;

    function automatic int m_ready(input int r);
        if (!m_pend[r]) return 1;
        if (m_bcd[r] && (m_e - m_bce[r]) >= m_lat[r] - 1) return 1;
        return 0;
    endfunction

    function automatic int m_match(input int r);
        return (!m_pend[r] || m_bcd[r]) ? 1 : 0;
    endfunction

    function automatic int m_cnt(input int r);
        int rem;
        if (!m_pend[r] || !m_bcd[r]) return 0;
        rem = m_lat[r] - 1 - (m_e - m_bce[r]);
        return (rem > 0) ? rem : 0;
    endfunction

    function automatic int lat_of(input int t);
        case (t)
            3: return 3;
            4: return 4;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_pend[r] = 0;
            m_bcd[r]  = 0;
            m_lat[r]  = 1;
            m_bce[r]  = 0;
        end
    endtask

    task automatic model_edge();
        int r;
        m_e++;
        if (reset) begin
            model_reset();
            return;
        end
        for (int j = 0; j < BW; j++) begin
            r = int'(bc_dst[j*SEL +: SEL]);
            if (bc_valid[j] && r != 0) begin
                m_bcd[r] = 1;
                m_bce[r] = m_e;
            end
        end
        for (int k = 0; k < DW; k++) begin
            r = int'(disp_dst[k*SEL +: SEL]);
            if (disp_valid[k] && disp_wr_reg[k] && r != 0) begin
                m_pend[r] = 1;
                m_bcd[r]  = 0;
                m_lat[r]  = lat_of(int'(disp_type[k*TW +: TW]));
            end
        end
`ifdef SCOREBOARD_RECOVERY_EN
        if (flush_valid) begin
            for (int q = 1; q < NR; q++) begin
                if (flush_mask[q]) m_pend[q] = 0;
            end
        end
`endif
    endtask

    task automatic set_idle();
        reset = 1'b0; disp_valid = '0; disp_wr_reg = '0;
        disp_src1 = '0; disp_src2 = '0; disp_dst = '0; disp_type = '0;
        bc_valid = '0; bc_dst = '0;
`ifdef SCOREBOARD_RECOVERY_EN
        flush_valid = 1'b0; flush_mask = '0;
`endif
    endtask

    // Inputs are already applied; check every source lookup and busy_cnt, then clock.
    task automatic step();
        int r1, r2, busy;
        #1;
        for (int k = 0; k < DW; k++) begin
            r1 = int'(disp_src1[k*SEL +: SEL]);
            r2 = int'(disp_src2[k*SEL +: SEL]);
            check("src1_ready", int'(src1_ready[k]), disp_valid[k] ? m_ready(r1) : 0);
            check("src1_match", int'(src1_match[k]), disp_valid[k] ? m_match(r1) : 0);
            check("src1_cnt", int'(src1_cnt[k*LW +: LW]), disp_valid[k] ? m_cnt(r1) : 0);
            check("src2_ready", int'(src2_ready[k]), disp_valid[k] ? m_ready(r2) : 0);
            check("src2_match", int'(src2_match[k]), disp_valid[k] ? m_match(r2) : 0);
            check("src2_cnt", int'(src2_cnt[k*LW +: LW]), disp_valid[k] ? m_cnt(r2) : 0);
        end
        busy = 0;
        for (int r = 0; r < NR; r++) busy += (m_ready(r) == 0) ? 1 : 0;
        check("busy_cnt", int'(busy_cnt), busy);
        @(posedge clk);
        model_edge();
    endtask

    task automatic read_slot(input int k, input int tag);
        disp_valid[k] = 1'b1;
        disp_src1[k*SEL +: SEL] = SEL'(tag);
    endtask

    task automatic chk_slot(input string tag, input int k, input int rdy, input int mt, input int c);
        #1;
        check({tag, "_ready"}, int'(src1_ready[k]), rdy);
        check({tag, "_match"}, int'(src1_match[k]), mt);
        check({tag, "_cnt"}, int'(src1_cnt[k*LW +: LW]), c);
    endtask

    task automatic disp(input int k, input int dst, input int typ);
        disp_valid[k] = 1'b1;
        disp_wr_reg[k] = 1'b1;
        disp_dst[k*SEL +: SEL] = SEL'(dst);
        disp_type[k*TW +: TW] = TW'(typ);
    endtask

    task automatic random_inputs();
        int r;
        set_idle();
        reset = ($urandom_range(0, 63) == 0);
        disp_valid  = DW'($urandom);
        disp_wr_reg = DW'($urandom);
        for (int k = 0; k < DW; k++) begin
            disp_src1[k*SEL +: SEL] = SEL'($urandom_range(0, 15));
            disp_src2[k*SEL +: SEL] = SEL'($urandom_range(0, 15));
            disp_dst[k*SEL +: SEL]  = SEL'($urandom_range(0, 15));
            disp_type[k*TW +: TW]   = TW'($urandom_range(0, 6));
        end
        for (int j = 0; j < BW; j++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int t = 0; t < 6; t++) begin
                    r = $urandom_range(1, 15);
                    if (m_pend[r] && !m_bcd[r]) begin
                        bc_valid[j] = 1'b1;
                        bc_dst[j*SEL +: SEL] = SEL'(r);
                        break;
                    end
                end
            end
        end
`ifdef SCOREBOARD_RECOVERY_EN
        flush_valid = ($urandom_range(0, 15) == 0);
        flush_mask  = {$urandom, $urandom} & {$urandom, $urandom};
`endif
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        m_e = 0;

        // Reset state read.
        @(negedge clk); set_idle(); read_slot(0, 5);
        chk_slot("rst_p5", 0, 1, 1, 0);
        check("rst_busy", int'(busy_cnt), 0);
        step();

        // MUL p7: dispatch, idle, broadcast, then count 2,1 and ready.
        @(negedge clk); set_idle(); disp(0, 7, 3); step();
        @(negedge clk); set_idle(); read_slot(0, 7); chk_slot("mul_t1", 0, 0, 0, 0);
        check("mul_busy", int'(busy_cnt), 1); step();
        @(negedge clk); set_idle(); read_slot(0, 7); bc_valid[0] = 1'b1; bc_dst[SEL-1:0] = SEL'(7);
        chk_slot("mul_t2", 0, 0, 0, 0); step();
        @(negedge clk); set_idle(); read_slot(0, 7); chk_slot("mul_t3", 0, 0, 1, 2); step();
        @(negedge clk); set_idle(); read_slot(0, 7); chk_slot("mul_t4", 0, 0, 1, 1); step();
        @(negedge clk); set_idle(); read_slot(0, 7); chk_slot("mul_t5", 0, 1, 1, 0); step();

        // ALU p9 with same-cycle read in slot 1: no bypass.
        @(negedge clk); set_idle(); disp(0, 9, 1); read_slot(1, 9);
        chk_slot("alu_t0", 1, 1, 1, 0); step();
        @(negedge clk); set_idle(); read_slot(1, 9); bc_valid[1] = 1'b1; bc_dst[SEL +: SEL] = SEL'(9);
        chk_slot("alu_t1", 1, 0, 0, 0); step();
        @(negedge clk); set_idle(); read_slot(1, 9); chk_slot("alu_t2", 1, 1, 1, 0); step();

        // Duplicate dst p4: slot 1 (ALU) wins over slot 0 (LDST).
        @(negedge clk); set_idle(); disp(0, 4, 4); disp(1, 4, 1); step();
        @(negedge clk); set_idle(); bc_valid[0] = 1'b1; bc_dst[SEL-1:0] = SEL'(4); step();
        @(negedge clk); set_idle(); read_slot(0, 4); chk_slot("dup_p4", 0, 1, 1, 0); step();

        // Writes to p0 are ignored.
        @(negedge clk); set_idle(); disp(0, 0, 3); step();
        @(negedge clk); set_idle(); read_slot(0, 0); chk_slot("p0", 0, 1, 1, 0);
        check("p0_busy", int'(busy_cnt), 0); step();

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            random_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
